// File: rtl/flex_updown_counter.sv
// Prescaled up/down counter over 1..rollover_val with sync load/clear, registered flags and a wrap pulse.
// Latency: one core clock from a qualifying input to count_out and flag update. No backpressure; the counter accepts every cycle.
// Optional saturation is built only when FLEX_CNT_SAT_EN is defined; otherwise sat_mode is ignored and the counter always wraps.
module flex_updown_counter #(
    parameter int NUM_CNT_BITS = 4,
    parameter int PRE_BITS     = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    sat_mode,
    input  logic [PRE_BITS-1:0]     prescale_val,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag,
    output logic                    bottom_flag,
    output logic                    wrap_pulse
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [PRE_BITS-1:0]     pre_cnt;
    logic                    step;
    logic                    sat;
    logic [NUM_CNT_BITS:0]   cnt_inc;
    logic [NUM_CNT_BITS-1:0] next_cnt;
    logic                    next_wrap;

`ifdef FLEX_CNT_SAT_EN
    assign sat = sat_mode;
`else
    logic unused_sat_mode;
    assign unused_sat_mode = sat_mode;
    assign sat = 1'b0;
`endif

    assign step = count_enable && (pre_cnt == prescale_val);

    // Widened increment so an all-ones count never aliases to zero in the range test.
    assign cnt_inc = {1'b0, count_out} + (NUM_CNT_BITS + 1)'(1);

    always_comb begin
        next_cnt  = count_out;
        next_wrap = 1'b0;
        if (rollover_val == '0) begin
            next_cnt = '0;
        end else if (!count_down) begin
            if (cnt_inc <= {1'b0, rollover_val}) begin
                next_cnt = cnt_inc[NUM_CNT_BITS-1:0];
            end else if (sat) begin
                next_cnt = rollover_val;
            end else begin
                next_cnt  = CNT_ONE;
                next_wrap = 1'b1;
            end
        end else begin
            if (count_out > rollover_val) begin
                next_cnt = rollover_val;
            end else if (count_out <= CNT_ONE) begin
                if (sat) begin
                    next_cnt = CNT_ONE;
                end else begin
                    next_cnt  = rollover_val;
                    next_wrap = 1'b1;
                end
            end else begin
                next_cnt = count_out - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            pre_cnt       <= '0;
            rollover_flag <= 1'b0;
            bottom_flag   <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else if (clear) begin
            count_out     <= '0;
            pre_cnt       <= '0;
            rollover_flag <= 1'b0;
            bottom_flag   <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else if (load) begin
            count_out     <= load_val;
            pre_cnt       <= '0;
            rollover_flag <= 1'b0;
            bottom_flag   <= 1'b0;
            wrap_pulse    <= 1'b0;
        end else if (step) begin
            count_out     <= next_cnt;
            pre_cnt       <= '0;
            // Flags describe the new count; with a zero range both stay low.
            rollover_flag <= (rollover_val != '0) && (next_cnt == rollover_val);
            bottom_flag   <= (next_cnt == CNT_ONE);
            wrap_pulse    <= next_wrap;
        end else begin
            if (count_enable) begin
                pre_cnt <= pre_cnt + PRE_BITS'(1);
            end
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed-vector bench for flex_updown_counter with hand-computed expectations.
module tb_flex_updown_counter;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       count_enable;
    logic       count_down;
    logic       sat_mode;
    logic [3:0] prescale_val;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic       bottom_flag;
    logic       wrap_pulse;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    flex_updown_counter #(.NUM_CNT_BITS(4), .PRE_BITS(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
        .count_down   (count_down),
        .sat_mode     (sat_mode),
        .prescale_val (prescale_val),
        .rollover_val (rollover_val),
        .count_out    (count_out),
        .rollover_flag(rollover_flag),
        .bottom_flag  (bottom_flag),
        .wrap_pulse   (wrap_pulse)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance one clock, then compare all four outputs.
    task automatic tick_chk(input string tag, input int cnt, input int rf, input int bf, input int wp);
        tick();
        check_val({tag, ".cnt"}, int'(count_out), cnt);
        check_val({tag, ".rf"}, int'(rollover_flag), rf);
        check_val({tag, ".bf"}, int'(bottom_flag), bf);
        check_val({tag, ".wp"}, int'(wrap_pulse), wp);
    endtask

    task automatic do_load(input logic [3:0] v);
        load = 1'b1; load_val = v; tick(); load = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        count_enable = 1'b0; count_down = 1'b0; sat_mode = 1'b0;
        prescale_val = '0; rollover_val = '0;
        #12;
        check_val("rst.cnt", int'(count_out), 0);
        check_val("rst.flags", int'({rollover_flag, bottom_flag, wrap_pulse}), 0);
        n_rst = 1'b1;
        tick();

        // 1: R=4 pre=0 up from reset.
        rollover_val = 4'd4; count_enable = 1'b1;
        tick_chk("t1a", 1, 0, 1, 0);
        tick_chk("t1b", 2, 0, 0, 0);
        tick_chk("t1c", 3, 0, 0, 0);
        tick_chk("t1d", 4, 1, 0, 0);
        tick_chk("t1e", 1, 0, 1, 1);
        tick_chk("t1f", 2, 0, 0, 0);
        count_enable = 1'b0;
        tick_chk("t1hold", 2, 0, 0, 0);

        // 2: R=5 pre=2, step on every third enabled cycle.
        do_clear();
        rollover_val = 4'd5; prescale_val = 4'd2; count_enable = 1'b1;
        tick_chk("t2c1", 0, 0, 0, 0);
        tick_chk("t2c2", 0, 0, 0, 0);
        tick_chk("t2c3", 1, 0, 1, 0);
        tick_chk("t2c4", 1, 0, 1, 0);
        tick_chk("t2c5", 1, 0, 1, 0);
        tick_chk("t2c6", 2, 0, 0, 0);
        tick();
        tick();
        tick_chk("t2c9", 3, 0, 0, 0);

        // 3: load wins over enable, then count down through the wrap.
        prescale_val = 4'd0; rollover_val = 4'd3; count_down = 1'b1;
        load = 1'b1; load_val = 4'd3;
        tick_chk("t3load", 3, 0, 0, 0);
        load = 1'b0;
        tick_chk("t3a", 2, 0, 0, 0);
        tick_chk("t3b", 1, 0, 1, 0);
        tick_chk("t3c", 3, 1, 0, 1);
        tick_chk("t3d", 2, 0, 0, 0);

        // 4: saturation, or sat_mode ignored when the feature is not built.
        count_enable = 1'b0; count_down = 1'b0; sat_mode = 1'b1; rollover_val = 4'd6;
        do_load(4'd5);
        count_enable = 1'b1;
`ifdef FLEX_CNT_SAT_EN
        tick_chk("t4up1", 6, 1, 0, 0);
        tick_chk("t4up2", 6, 1, 0, 0);
        tick_chk("t4up3", 6, 1, 0, 0);
        count_enable = 1'b0; count_down = 1'b1;
        do_load(4'd2);
        count_enable = 1'b1;
        tick_chk("t4dn1", 1, 0, 1, 0);
        tick_chk("t4dn2", 1, 0, 1, 0);
`else
        tick_chk("t4up1", 6, 1, 0, 0);
        tick_chk("t4wrap", 1, 0, 1, 1);
`endif
        sat_mode = 1'b0;

        // 5: out-of-range load, then step up/down and clear-with-enable.
        count_enable = 1'b0; count_down = 1'b0; rollover_val = 4'd7;
        do_load(4'd12);
        count_enable = 1'b1;
        tick_chk("t5up", 1, 0, 1, 1);
        count_enable = 1'b0; count_down = 1'b1;
        do_load(4'd12);
        count_enable = 1'b1;
        tick_chk("t5dn", 7, 1, 0, 0);
        count_enable = 1'b0;
        do_load(4'd12);
        clear = 1'b1; count_enable = 1'b1;
        tick_chk("t5clr", 0, 0, 0, 0);
        clear = 1'b0; count_enable = 1'b0;

        // Range edges: R=1, R=0, all-ones.
        count_down = 1'b0; rollover_val = 4'd1; count_enable = 1'b1;
        tick_chk("r1up0", 1, 1, 1, 0);
        tick_chk("r1up1", 1, 1, 1, 1);
        count_down = 1'b1;
        tick_chk("r1dn", 1, 1, 1, 1);
        rollover_val = 4'd0;
        tick_chk("r0dn", 0, 0, 0, 0);
        tick_chk("r0dn2", 0, 0, 0, 0);
        count_down = 1'b0;
        tick_chk("r0up", 0, 0, 0, 0);
        count_enable = 1'b0; rollover_val = 4'd15;
        do_load(4'd14);
        count_enable = 1'b1;
        tick_chk("r15a", 15, 1, 0, 0);
        tick_chk("r15b", 1, 0, 1, 1);

        // 6: async reset mid-count (count=3, pre_cnt=1), then restart.
        count_enable = 1'b0;
        do_clear();
        rollover_val = 4'd3; prescale_val = 4'd2; count_enable = 1'b1;
        repeat (9) tick();
        check_val("t6pre.cnt", int'(count_out), 3);
        check_val("t6pre.rf", int'(rollover_flag), 1);
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        check_val("t6rst.cnt", int'(count_out), 0);
        check_val("t6rst.flags", int'({rollover_flag, bottom_flag, wrap_pulse}), 0);
        #1;
        n_rst = 1'b1;
        tick_chk("t6r1", 0, 0, 0, 0);
        tick_chk("t6r2", 0, 0, 0, 0);
        tick_chk("t6r3", 1, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
